// File: rtl/channel_ctrl_if.sv
// Event FIFO read port of channel_ctrl: the consumer pops first-word-fall-through
// entries laid out as {timestamp, adc}.
interface channel_ctrl_if #(
  parameter int ADCBITS = 10,
  parameter int TS_BITS = 16
);
  logic                       fifo_rd;
  logic [TS_BITS+ADCBITS-1:0] fifo_data;
  logic                       fifo_empty;

  modport master (output fifo_rd, input fifo_data, input fifo_empty);
  modport slave  (input fifo_rd, output fifo_data, output fifo_empty);
endinterface

// File: rtl/channel_ctrl.sv
// Front-end channel sequencer: hit detect, hold, ADC sample/convert, timestamped
// event FIFO and CSA re-arm, with sticky overflow and ADC-timeout flags.
module channel_ctrl #(
  parameter int ADCBITS    = 10,
  parameter int TS_BITS    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hit,
  input  logic               done,
  input  logic [ADCBITS-1:0] dout,
  input  logic               enable,
  input  logic [TS_BITS-1:0] timestamp,
  input  logic [3:0]         hold_cycles,
  input  logic [3:0]         reset_cycles,
  output logic               sample,
  output logic               strobe,
  output logic               csa_reset,
  output logic               overflow,
  output logic               timeout,
  channel_ctrl_if.slave      fifo_if
);
  localparam int ENTRY_W = TS_BITS + ADCBITS;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [5:0] SAMPLE_LAST = 6'd3;
  localparam logic [5:0] CONV_LAST   = 6'd31;

  typedef enum logic [2:0] {
    IDLE, HOLD, SAMPLE, CONVERT, STORE, RESET_CSA
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               hit_meta_q, hit_s_q, done_meta_q, done_s_q;
  logic               sample_q, sample_d, strobe_q, strobe_d;
  logic               csa_reset_q, csa_reset_d;
  logic               overflow_q, overflow_d, timeout_q, timeout_d;
  logic [TS_BITS-1:0] ts_reg_q, ts_reg_d;
  logic [ADCBITS-1:0] adc_reg_q, adc_reg_d;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic               empty, full, push, pop;
  logic [5:0]         hold_last, reset_last;

  // Last count value of HOLD / RESET_CSA; a zero setting behaves like one.
  always_comb begin
    hold_last  = (hold_cycles  == 4'd0) ? 6'd0 : {2'b00, hold_cycles}  - 6'd1;
    reset_last = (reset_cycles == 4'd0) ? 6'd0 : {2'b00, reset_cycles} - 6'd1;
  end

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
               (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    pop      = fifo_if.fifo_rd && !empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    push     = (state_q == STORE) && (!full || pop);
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 6'd1;
    ts_reg_d   = ts_reg_q;
    adc_reg_d  = adc_reg_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable && hit_s_q) begin
          ts_reg_d = timestamp;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q >= hold_last) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          state_d = CONVERT;
          cnt_d   = '0;
        end
      end
      CONVERT: begin
        if (done_s_q) begin
          adc_reg_d = dout;
          state_d   = STORE;
          cnt_d     = '0;
        end else if (cnt_q == CONV_LAST) begin
          timeout_d = 1'b1;
          state_d   = RESET_CSA;
          cnt_d     = '0;
        end
      end
      STORE: begin
        overflow_d = overflow_q | ~push;
        state_d    = RESET_CSA;
        cnt_d      = '0;
      end
      RESET_CSA: begin
        if (cnt_q >= reset_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered copies of the state being entered.
    sample_d    = (state_d == SAMPLE);
    strobe_d    = (state_q == SAMPLE) && (state_d == CONVERT);
    csa_reset_d = (state_d == RESET_CSA);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hit_meta_q  <= 1'b0;
      hit_s_q     <= 1'b0;
      done_meta_q <= 1'b0;
      done_s_q    <= 1'b0;
      sample_q    <= 1'b0;
      strobe_q    <= 1'b0;
      csa_reset_q <= 1'b1;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hit_meta_q  <= hit;
      hit_s_q     <= hit_meta_q;
      done_meta_q <= done;
      done_s_q    <= done_meta_q;
      sample_q    <= sample_d;
      strobe_q    <= strobe_d;
      csa_reset_q <= csa_reset_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Event payload registers and FIFO storage carry no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    ts_reg_q  <= ts_reg_d;
    adc_reg_q <= adc_reg_d;
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= {ts_reg_q, adc_reg_q};
    end
  end

  assign sample             = sample_q;
  assign strobe             = strobe_q;
  assign csa_reset          = csa_reset_q;
  assign overflow           = overflow_q;
  assign timeout            = timeout_q;
  assign fifo_if.fifo_data  = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign fifo_if.fifo_empty = empty;
endmodule

// File: tb/tb_channel_ctrl.sv
// Randomized bench for channel_ctrl against a transaction-level model of event
// timing, FIFO contents and sticky flags.
module tb_channel_ctrl;
  localparam int ADCBITS    = 10;
  localparam int TS_BITS    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int ENTRY_W    = TS_BITS + ADCBITS;

  logic               clk = 1'b0;
  logic               reset_n, hit, done, enable;
  logic [ADCBITS-1:0] dout;
  logic [TS_BITS-1:0] timestamp, ts_base;
  logic [3:0]         hold_cycles, reset_cycles;
  logic               sample, strobe, csa_reset, overflow, timeout;
  int                 cyc = 0;

  channel_ctrl_if #(.ADCBITS(ADCBITS), .TS_BITS(TS_BITS)) fifo_if ();

  channel_ctrl #(.ADCBITS(ADCBITS), .TS_BITS(TS_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .hit(hit), .done(done), .dout(dout),
    .enable(enable), .timestamp(timestamp), .hold_cycles(hold_cycles),
    .reset_cycles(reset_cycles), .sample(sample), .strobe(strobe),
    .csa_reset(csa_reset), .overflow(overflow), .timeout(timeout),
    .fifo_if(fifo_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign timestamp = ts_base + cyc[15:0];

  int                 n_checks = 0;
  int                 n_errors = 0;
  logic [ENTRY_W-1:0] m_q [$];
  bit                 m_ovf, m_tmo;
  int                 last_idle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One event from detect to return to IDLE; called and returns on a falling edge.
  // dly < 0 means the ADC never answers. Edge numbers follow 'cyc'.
  task automatic run_event(input bit fresh, input int h, input int rc, input int dly,
                           input bit pop_st, input bit keep_hit, input bit drop_en,
                           input int want_ts, input int adc_val);
    int det, hh, rr, s, csa_exp;
    int smp_first = -1, smp_cnt = 0, stb_at = -1, stb_cnt = 0, csa_first = -1, csa_cnt = 0;
    bit ended = 0, popped, was_full;
    logic [ADCBITS-1:0] dv;
    logic [TS_BITS-1:0] ets;
    hold_cycles  = 4'(h);
    reset_cycles = 4'(rc);
    hh  = (h == 0) ? 1 : h;
    rr  = (rc == 0) ? 1 : rc;
    // Fresh hit: two synchronizer flops, then IDLE acts on the next edge.
    det = fresh ? cyc + 3 : last_idle + 1;
    if (fresh) hit = 1'b1;
    if (want_ts >= 0) ts_base = 16'(want_ts - (det - 1));
    dv  = (adc_val >= 0) ? ADCBITS'(adc_val) : ADCBITS'($urandom_range(0, 1023));
    s   = det + hh + 4;
    csa_exp = (dly >= 0) ? s + dly + 4 : s + 32;
    for (int g = 0; g < 200 && !ended; g++) begin
      @(negedge clk);
      if (sample) begin smp_cnt++; if (smp_first < 0) smp_first = cyc; end
      if (strobe) begin stb_cnt++; stb_at = cyc; end
      if (csa_reset) begin csa_cnt++; if (csa_first < 0) csa_first = cyc; end
      else if (csa_first >= 0) ended = 1;
      if (dly < 0 && cyc == s + 31) check("timeout_before", timeout, m_tmo);
      if (dly < 0 && cyc == s + 32) check("timeout_at_32", timeout, 1);
      if (!keep_hit && cyc == det) hit = 1'b0;
      if (drop_en && cyc == det) enable = 1'b0;
      if (dly >= 0 && cyc == s + dly) begin done = 1'b1; dout = dv; end
      if (dly >= 0 && cyc == s + dly + 4) done = 1'b0;
      fifo_if.fifo_rd = 1'b0;
      if (pop_st && dly >= 0 && cyc == s + dly + 3) begin
        if (m_q.size() > 0) check("store_pop_data", fifo_if.fifo_data, m_q[0]);
        fifo_if.fifo_rd = 1'b1;
      end
    end
    if (!ended) check("event_end", 0, 1);
    last_idle = cyc;
    ets = ts_base + 16'(det - 1);
    if (dly >= 0) begin
      was_full = (m_q.size() >= FIFO_DEPTH);
      popped   = pop_st && (m_q.size() > 0);
      if (popped) void'(m_q.pop_front());
      if (!was_full || popped) m_q.push_back({ets, dv});
      else m_ovf = 1;
    end else begin
      m_tmo = 1;
    end
    check("sample_start", smp_first, det + hh);
    check("sample_len", smp_cnt, 4);
    check("strobe_at", stb_at, s);
    check("strobe_len", stb_cnt, 1);
    check("csa_start", csa_first, csa_exp);
    check("csa_len", csa_cnt, rr);
    check("timeout_flag", timeout, m_tmo);
    check("overflow_flag", overflow, m_ovf);
    check("fifo_empty", fifo_if.fifo_empty, m_q.size() == 0);
    if (m_q.size() > 0) check("fifo_head", fifo_if.fifo_data, m_q[0]);
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (m_q.size() == 0) begin
        check("rd_empty_flag", fifo_if.fifo_empty, 1);
        check("rd_empty_data", fifo_if.fifo_data, 0);
      end else begin
        check("rd_flag", fifo_if.fifo_empty, 0);
        check("rd_data", fifo_if.fifo_data, m_q[0]);
        void'(m_q.pop_front());
      end
      fifo_if.fifo_rd = 1'b1;
      @(negedge clk);
      fifo_if.fifo_rd = 1'b0;
    end
    check("drain_empty", fifo_if.fifo_empty, m_q.size() == 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_csa"}, csa_reset, 1);
    check({tag, "_sample"}, sample, 0);
    check({tag, "_strobe"}, strobe, 0);
    check({tag, "_empty"}, fifo_if.fifo_empty, 1);
    check({tag, "_data"}, fifo_if.fifo_data, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_tmo"}, timeout, 0);
  endtask

  initial begin
    int quiet;
    bit chain, keep, seen;
    reset_n = 1'b0; hit = 1'b0; done = 1'b0; dout = '0; enable = 1'b1;
    hold_cycles = '0; reset_cycles = '0; ts_base = '0; fifo_if.fifo_rd = 1'b0;
    m_ovf = 0; m_tmo = 0; last_idle = 0;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check("csa_release", csa_reset, 0);

    // Single event with known timestamp and ADC word.
    run_event(1, 2, 3, 6, 0, 0, 0, 'h1234, 'h155);
    check("first_entry", fifo_if.fifo_data, {16'h1234, 10'h155});
    drain(1);

    // Fill, then store while full with a coincident pop.
    for (int i = 0; i < 4; i++)
      run_event(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(1, 20), 0, 0, 0, -1, -1);
    run_event(1, 1, 1, 3, 1, 0, 0, -1, -1);
    check("full_pop_no_ovf", overflow, 0);
    drain(5);

    // Five events with no reads: the fifth is dropped.
    for (int i = 0; i < 5; i++)
      run_event(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(1, 20), 0, 0, 0, -1, -1);
    check("ovf_after_five", overflow, 1);
    drain(4);

    // ADC never answers.
    run_event(1, 0, 0, -1, 0, 0, 0, -1, -1);

    // Hit held high: back-to-back retriggers.
    run_event(1, 1, 2, 5, 0, 1, 0, -1, -1);
    run_event(0, 3, 0, 8, 0, 1, 0, -1, -1);
    run_event(0, 0, 4, 2, 0, 0, 0, -1, -1);
    drain(3);

    // Enable dropped mid-event: event completes, later hits ignored.
    run_event(1, 2, 2, 4, 0, 0, 1, -1, -1);
    hit = 1'b1;
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (sample || strobe || csa_reset) quiet++;
    end
    check("disabled_quiet", quiet, 0);
    hit = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    drain(1);

    // Randomized events.
    chain = 0;
    for (int i = 0; i < 16; i++) begin
      keep = ($urandom_range(0, 3) == 0) && (i < 15);
      run_event(!chain, $urandom_range(0, 15), $urandom_range(0, 15),
                ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 20)),
                $urandom_range(0, 2) == 0, keep, 0, -1, -1);
      chain = keep;
      if (!keep && $urandom_range(0, 1) == 1) drain($urandom_range(0, 3));
    end
    drain(5);

    // Reset in the middle of a conversion discards the event.
    run_event(1, 1, 1, 3, 0, 0, 0, -1, -1);
    hit = 1'b1;
    seen = 0;
    for (int g = 0; g < 60 && !seen; g++) begin
      @(negedge clk);
      if (strobe) seen = 1;
    end
    check("strobe_before_reset", seen, 1);
    hit = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    reset_checks("midrst");
    m_q.delete(); m_ovf = 0; m_tmo = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_csa_release", csa_reset, 0);
    done = 1'b1; dout = 10'h3ff;
    repeat (5) @(negedge clk);
    done = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_no_entry", fifo_if.fifo_empty, 1);
    check("midrst_ovf", overflow, 0);
    check("midrst_tmo", timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/channel_ctrl.md
CHANNEL_CTRL -- requirements
Module: channel_ctrl

Interface
REQ-001 SHALL have parameter ADCBITS, default 10, meaning ADC word width.
REQ-002 SHALL have parameter TS_BITS, default 16, meaning timestamp width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning event FIFO entries (power of 2).
REQ-004 SHALL have port clk  input  1  single system clock, all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port hit  input  1  discriminator output from analog channel, asynchronous to clk.
REQ-007 SHALL have port done  input  1  ADC conversion-complete, asynchronous to clk.
REQ-008 SHALL have port dout  input  ADCBITS  ADC result, stable while done high.
REQ-009 SHALL have port enable  input  1  channel enable.
REQ-010 SHALL have port timestamp  input  TS_BITS  free-running time counter.
REQ-011 SHALL have port hold_cycles  input  4  wait after hit before sampling.
REQ-012 SHALL have port reset_cycles  input  4  CSA reset pulse length (0 treated as 1).
REQ-013 SHALL have port sample  output  1  track command to ADC.
REQ-014 SHALL have port strobe  output  1  one-cycle conversion-start pulse to ADC.
REQ-015 SHALL have port csa_reset  output  1  CSA reset/arm to analog channel.
REQ-016 SHALL have port fifo_rd  input  1  pop request.
REQ-017 SHALL have port fifo_data  output  TS_BITS+ADCBITS  head entry {timestamp, adc}.
REQ-018 SHALL have port fifo_empty  output  1  FIFO empty.
REQ-019 SHALL have port overflow  output  1  sticky event-dropped flag.
REQ-020 SHALL have port timeout  output  1  sticky ADC-timeout flag.

Function
REQ-021 SHALL synchronize hit and done each through two flops; all decisions use synchronized versions (hit_s, done_s).
REQ-022 SHALL implement states IDLE, HOLD, SAMPLE, CONVERT, STORE, RESET_CSA.
REQ-023 IDLE: when enable=1 and hit_s=1, SHALL latch timestamp into ts_reg and go to HOLD next cycle.
REQ-024 HOLD: SHALL stay exactly hold_cycles cycles (0 = pass through in one cycle) then go to SAMPLE.
REQ-025 SAMPLE: sample SHALL be 1 for exactly 4 cycles; on exit strobe SHALL be 1 for one cycle as CONVERT is entered.
REQ-026 CONVERT: on done_s=1 SHALL capture dout into adc_reg and go to STORE.
REQ-027 CONVERT: if done_s not seen within 32 cycles of entry SHALL set timeout and go to RESET_CSA without storing.
REQ-028 STORE: one cycle; SHALL push {ts_reg, adc_reg} if FIFO not full or fifo_rd=1 same cycle; else drop and set overflow; then RESET_CSA.
REQ-029 RESET_CSA: csa_reset SHALL be 1 for max(reset_cycles,1) cycles, then IDLE; csa_reset is 0 in all other states.
REQ-030 hit_s remaining high on return to IDLE SHALL retrigger (level-sensitive); no hit is lost-counted while busy.
REQ-031 enable deasserted mid-event SHALL NOT abort; event completes, then IDLE ignores hit_s.
REQ-032 FIFO SHALL be first-word-fall-through: fifo_data valid whenever fifo_empty=0; fifo_rd while empty ignored.
REQ-033 Simultaneous push and pop SHALL leave occupancy unchanged, including at full and (pop-ignored) at empty.
REQ-034 Read/write pointers SHALL wrap modulo FIFO_DEPTH using one extra bit for full/empty.
REQ-035 overflow and timeout SHALL clear only on reset.

Reset
REQ-036 During reset_n=0: state IDLE, sample=0, strobe=0, csa_reset=1, FIFO empty, fifo_data=0, overflow=0, timeout=0, synchronizers 0.
REQ-037 After reset release csa_reset SHALL drop on first clk edge; reset mid-event SHALL discard the event.

Verification
REQ-038 enable=1, hold_cycles=2, hit pulse, done 6 cycles after strobe with dout=0x155, timestamp=0x1234 at detect -> one entry {0x1234,0x155}, csa_reset high reset_cycles cycles.
REQ-039 Five events with no fifo_rd, FIFO_DEPTH=4 -> four entries held, fifth dropped, overflow=1.
REQ-040 FIFO full, STORE coincident with fifo_rd -> push accepted, overflow stays 0, order preserved.
REQ-041 done never asserted -> timeout=1 at 32 cycles after strobe, no push, csa_reset pulse, return IDLE.
REQ-042 hit held high continuously -> back-to-back events each separated by RESET_CSA pulse.
REQ-043 reset_n asserted during CONVERT -> csa_reset=1, FIFO empty, no entry written after release.
